// File: rtl/fetch_ctrl.sv
// Next-PC selection for the fetch stage: trap, eret, branch redirect,
// stall hold and sequential fetch, plus stall counter and PC range flag.
//
// Ports:
//   clk, res            clock, async active-low reset
//   pc                  current fetch PC
//   stall               decode hazard stall
//   br_taken, br_target resolved branch redirect
//   req                 exception/interrupt request
//   eret, epc           return from exception
//   npc, pc_we          next PC and its write enable (same cycle)
//   flush               squash the IF/ID instruction
//   state               0 RUN, 1 HOLD, 2 TRAP
//   stall_cnt           consecutive stalled cycles, saturating
//   pc_err              last written npc misaligned or out of range
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        flush,
  output logic [1:0]  state,
  output logic [7:0]  stall_cnt,
  output logic        pc_err
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } st_e;

  st_e         st;
  st_e         st_nxt;
  logic [31:0] pend;
  logic [31:0] pend_nxt;
  logic [31:0] pc_inc;
  logic [31:0] sel_npc;
  logic        sel_we;
  logic        sel_fl;
  logic        npc_bad;

  assign state  = st;
  assign pc_inc = pc + 32'd4;

  always_comb begin
    sel_npc  = pc_inc;
    sel_we   = 1'b0;
    sel_fl   = 1'b0;
    st_nxt   = RUN;
    pend_nxt = pend;
    if (req) begin
      sel_npc  = HANDLER_PC;
      sel_we   = 1'b1;
      sel_fl   = 1'b1;
      pend_nxt = '0;
      st_nxt   = TRAP;
    end else if (eret && st != TRAP) begin
      sel_npc  = epc;
      sel_we   = 1'b1;
      sel_fl   = 1'b1;
      pend_nxt = '0;
      st_nxt   = RUN;
    end else begin
      unique case (st)
        RUN: begin
          if (br_taken && stall) begin
            // redirect arrives under a stall: park it
            pend_nxt = br_target;
            st_nxt   = HOLD;
          end else if (br_taken) begin
            sel_npc = br_target;
            sel_we  = 1'b1;
          end else begin
            sel_we = !stall;
          end
        end
        HOLD: begin
          if (stall) begin
            st_nxt = HOLD;
          end else begin
            sel_npc = pend;
            sel_we  = 1'b1;
          end
        end
        TRAP: begin
          sel_we = !stall;
        end
        default: begin
          st_nxt = RUN;
        end
      endcase
    end
  end

  // reset forces the outputs without waiting for a clock edge
  assign npc   = res ? sel_npc : RESET_PC;
  assign pc_we = res & sel_we;
  assign flush = res & sel_fl;

  assign npc_bad = (npc[1:0] != 2'b00)
                 || (npc < RESET_PC)
                 || (npc > IM_TOP);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st        <= RUN;
      pend      <= '0;
      stall_cnt <= '0;
      pc_err    <= 1'b0;
    end else begin
      st   <= st_nxt;
      pend <= pend_nxt;
      if (pc_we) begin
        stall_cnt <= '0;
      end else if (stall && stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (pc_we) begin
        pc_err <= npc_bad;
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, first fetch address and low bound of instruction memory.
REQ-002 Parameter HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry.
REQ-003 Parameter IM_TOP, 32'h0000_6FFF, highest valid instruction byte address.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port res, input, 1, reset, asynchronous and active-low.
REQ-006 Port pc, input, 32, current fetch PC driven by the fetch unit.
REQ-007 Port stall, input, 1, hazard stall from decode; freezes fetch.
REQ-008 Port br_taken, input, 1, branch/jump resolved taken this cycle.
REQ-009 Port br_target, input, 32, redirect address, valid with br_taken.
REQ-010 Port req, input, 1, exception/interrupt request from the coprocessor.
REQ-011 Port eret, input, 1, return-from-exception in decode.
REQ-012 Port epc, input, 32, return address, valid with eret.
REQ-013 Port npc, output, 32, next PC to the fetch unit.
REQ-014 Port pc_we, output, 1, PC write enable to the fetch unit.
REQ-015 Port flush, output, 1, squash the instruction in the fetch/decode register.
REQ-016 Port state, output, 2, FSM state: 0 RUN, 1 HOLD, 2 TRAP.
REQ-017 Port stall_cnt, output, 8, consecutive stall cycles, registered.
REQ-018 Port pc_err, output, 1, registered flag: last written npc misaligned or outside [RESET_PC, IM_TOP].

Function
REQ-019 Decision priority SHALL be req > eret > br_taken/pending redirect > stall > sequential, evaluated combinationally each cycle.
REQ-020 req=1 in any state: npc=HANDLER_PC, pc_we=1, flush=1, pending redirect cleared, next state TRAP; stall is ignored.
REQ-021 eret=1 (req=0, state RUN or HOLD): npc=epc, pc_we=1, flush=1, pending cleared, next state RUN; stall is ignored.
REQ-022 RUN, br_taken=1, stall=0: npc=br_target, pc_we=1, flush=0, stay RUN.
REQ-023 RUN, br_taken=1, stall=1: pc_we=0, br_target latched into 32-bit pending register, next state HOLD.
REQ-024 HOLD, stall=1: pc_we=0, pending retained; br_taken ignored.
REQ-025 HOLD, stall=0: npc=pending, pc_we=1, next state RUN.
REQ-026 TRAP lasts exactly one cycle: br_taken and eret ignored, stall honoured (pc_we=!stall, npc=pc+4), next state RUN unless req=1 again.
REQ-027 RUN, no event, stall=1: pc_we=0, npc=pc+4; stall=0: pc_we=1, npc=pc+4.
REQ-028 pc+4 SHALL wrap modulo 2^32 with no carry-out.
REQ-029 stall_cnt SHALL increment on each rising edge with stall=1 and pc_we=0, saturate at 255, and clear to 0 on any edge with pc_we=1.
REQ-030 On each edge with pc_we=1, pc_err SHALL load (npc[1:0]!=0 or npc<RESET_PC or npc>IM_TOP); it holds its value while pc_we=0.
REQ-031 Redirect latency SHALL be zero cycles: npc/pc_we reflect inputs in the same cycle, and the fetch unit updates at the next edge.
REQ-032 flush SHALL be 1 only in cycles where req or eret is accepted.

Reset
REQ-033 While res=0: state=RUN, pending=0, stall_cnt=0, pc_err=0, pc_we=0, flush=0, npc=RESET_PC, all independent of clk.
REQ-034 Reset asserted mid-HOLD or mid-TRAP SHALL discard the pending redirect; first cycle after release behaves as RUN.

Verification
REQ-035 Reset release, pc=0x3000, no events -> npc=0x3004, pc_we=1, state=0, pc_err=0.
REQ-036 pc=0x3010, stall=1 and br_taken=1 with br_target=0x3100, then stall held 3 cycles -> pc_we=0, state=1, stall_cnt=1,2,3; stall drops -> npc=0x3100, pc_we=1, next state=0, stall_cnt=0.
REQ-037 State HOLD (pending 0x3100) with req=1 -> npc=0x4180, flush=1, pc_we=1, state=2; next cycle br_taken=1 with 0x3200 -> ignored, npc=pc+4, state=0.
REQ-038 req=1 and eret=1 simultaneously with stall=1, epc=0x3050 -> npc=0x4180, pc_we=1, flush=1.
REQ-039 br_target=0x3002, then a separate test with br_target=0x7000 -> pc_err=1 after each edge; next sequential write to 0x3004 -> pc_err=0.
REQ-040 stall held 300 cycles -> stall_cnt saturates at 255; res pulsed low mid-stall -> stall_cnt=0 and npc=0x3000 immediately, with no clock edge required.
